// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: accepts one EXU load/store, drives the single-port data SRAM,
// and returns the aligned/extended result (or an error) to WBU.
module lsu_mem_initiator #(
  parameter int ADDR_W = 32,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_rdata,
  output logic              out_err,
  output logic [31:0]       mem_raddr,
  output logic              mem_r_en,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       mem_waddr,
  output logic              mem_w_en,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [31:0]       mem_wdata
);
  typedef enum logic [2:0] {IDLE, LD_REQ, LD_RESP, ST_REQ, DONE} state_e;
  state_e state_q, state_d;
  logic [2:0] funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q, result_q, ld_val, st_data, word_addr;
  logic err_q, legal_f3, misaligned, req_err;
  logic [15:0] lane;
  logic [3:0] st_mask;

  assign legal_f3 = in_is_store ? (in_funct3 inside {3'b000, 3'b001, 3'b010})
                                : (in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign misaligned = (in_funct3[1:0] == 2'b01 && in_addr[0]) ||
                      (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00);
  assign req_err = !legal_f3 || misaligned;

  // Halfwords are always 2-byte aligned here, so one byte-granular shift serves both sizes.
  assign lane = 16'(mem_rdata >> {addr_q[1:0], 3'b000});
  assign ld_val = funct3_q == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
                  funct3_q == 3'b001 ? {{16{lane[15]}}, lane} :
                  funct3_q == 3'b100 ? {24'h0, lane[7:0]} :
                  funct3_q == 3'b101 ? {16'h0, lane} : mem_rdata;

  assign st_mask = funct3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                   funct3_q[1:0] == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;
  assign st_data = (funct3_q[1:0] == 2'b00 ? {24'h0, wdata_q[7:0]} :
                    funct3_q[1:0] == 2'b01 ? {16'h0, wdata_q[15:0]} : wdata_q) << {addr_q[1:0], 3'b000};
  assign word_addr = 32'({addr_q[ADDR_W-1:2], 2'b00});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        funct3_q <= in_funct3;
        addr_q   <= in_addr;
        wdata_q  <= in_wdata;
        err_q    <= req_err;
        result_q <= '0;
      end
      // SRAM read data is only valid for this one cycle.
      if (state_q == LD_RESP) result_q <= ld_val;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:            if (in_valid) state_d = req_err ? DONE : in_is_store ? ST_REQ : LD_REQ;
      LD_REQ:          state_d = LD_RESP;
      LD_RESP, ST_REQ: state_d = DONE;
      DONE:            if (out_ready) state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    out_rdata = out_valid ? result_q : '0;
    out_err   = out_valid && err_q;
    mem_r_en  = state_q == LD_REQ;
    mem_raddr = mem_r_en ? word_addr : '0;
    mem_w_en  = state_q == ST_REQ;
    mem_waddr = mem_w_en ? word_addr : '0;
    mem_wmask = mem_w_en ? MASK_W'(st_mask) : '0;
    mem_wdata = mem_w_en ? st_data : '0;
  end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: directed load/store/error/reset vectors against a transaction-level model
module tb_lsu_mem_initiator;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_is_store = 0, out_ready = 0;
  logic [2:0] in_funct3 = 0;
  logic [31:0] in_addr = 0, in_wdata = 0, mem_rdata = 0;
  logic in_ready, out_valid, out_err, mem_r_en, mem_w_en;
  logic [31:0] out_rdata, mem_raddr, mem_waddr, mem_wdata;
  logic [7:0] mem_wmask;
  logic [31:0] sram [16];
  logic loaded = 0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_initiator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err), .mem_raddr(mem_raddr),
    .mem_r_en(mem_r_en), .mem_rdata(mem_rdata), .mem_waddr(mem_waddr), .mem_w_en(mem_w_en),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // SRAM: registered read, zero when not reading; byte-masked write at the edge.
  always @(posedge clk) begin
    if (!loaded) begin
      sram[0] <= 32'h80FF1234;
      sram[1] <= 32'h11223344;
      sram[2] <= 32'hCAFEF00D;
      sram[3] <= 32'h0BADC0DE;
      for (int i = 4; i < 16; i++) sram[i] <= 32'h0;
      loaded <= 1'b1;
    end
    mem_rdata <= mem_r_en ? sram[mem_raddr[5:2]] : 32'h0;
    if (mem_w_en)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) sram[mem_waddr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [2:0] f3, input int off);
    longint v = longint'(w >> (8 * off));
    longint b = v % 256;
    longint h = v % 65536;
    case (f3)
      3'd0: return 32'(b >= 128 ? b - 256 : b);
      3'd1: return 32'(h >= 32768 ? h - 65536 : h);
      3'd4: return 32'(b);
      3'd5: return 32'(h);
      default: return w;
    endcase
  endfunction

  // Transaction-level model: phase t counts cycles since acceptance.
  logic busy = 0, m_st = 0, m_err = 0, m_done, m_rq, m_legal;
  logic [31:0] m_addr = 0, m_res = 0, m_wmask = 0, m_wdata = 0;
  int t = 0, m_lat = 0, m_n, m_off;

  always @(negedge clk) begin
    if (rst) begin
      busy = 0;
      chk1("rst in_ready", in_ready, 1'b1);
      chk1("rst out_valid", out_valid, 1'b0);
      chk1("rst out_err", out_err, 1'b0);
      chk("rst out_rdata", out_rdata, 32'h0);
      chk1("rst mem_r_en", mem_r_en, 1'b0);
      chk1("rst mem_w_en", mem_w_en, 1'b0);
      chk("rst mem_raddr", mem_raddr, 32'h0);
      chk("rst mem_waddr", mem_waddr, 32'h0);
      chk("rst mem_wmask", 32'(mem_wmask), 32'h0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
    end else begin
      m_done = busy && t >= m_lat;
      m_rq = busy && t == 1 && !m_err;
      chk1("in_ready", in_ready, !busy);
      chk1("out_valid", out_valid, m_done);
      if (m_done) begin
        chk("out_rdata", out_rdata, m_res);
        chk1("out_err", out_err, m_err);
      end
      chk1("mem_r_en", mem_r_en, m_rq && !m_st);
      chk("mem_raddr", mem_raddr, (m_rq && !m_st) ? (m_addr & ~32'h3) : 32'h0);
      chk1("mem_w_en", mem_w_en, m_rq && m_st);
      chk("mem_waddr", mem_waddr, (m_rq && m_st) ? (m_addr & ~32'h3) : 32'h0);
      chk("mem_wmask", 32'(mem_wmask), (m_rq && m_st) ? m_wmask : 32'h0);
      chk("mem_wdata", mem_wdata, (m_rq && m_st) ? m_wdata : 32'h0);
      if (busy) begin
        if (m_done && out_ready) busy = 0;
        else t++;
      end else if (in_valid) begin
        m_st = in_is_store;
        m_addr = in_addr;
        m_n = 1 << in_funct3[1:0];
        m_off = int'(in_addr[1:0]);
        m_legal = in_is_store ? in_funct3 <= 3'd2
                              : (in_funct3 <= 3'd2 || in_funct3 == 3'd4 || in_funct3 == 3'd5);
        m_err = !m_legal || (m_off % m_n != 0);
        m_lat = m_err ? 1 : m_st ? 2 : 3;
        m_res = (m_err || m_st) ? 32'h0 : ld_model(sram[in_addr[5:2]], in_funct3, m_off);
        m_wmask = 32'(((1 << m_n) - 1) << m_off);
        m_wdata = 32'((m_n == 4 ? longint'(in_wdata) : longint'(in_wdata) % (longint'(1) << (8 * m_n))) << (8 * m_off));
        busy = 1;
        t = 1;
      end
    end
  end

  task automatic txn(input string name, input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_r, input logic exp_e, input int exp_lat,
                     input logic [7:0] exp_mask, input logic [31:0] exp_wd, input int hold, input logic rdy_hi);
    int k;
    @(posedge clk); #1;
    in_valid = 1; in_is_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd; out_ready = rdy_hi;
    @(posedge clk); #1;
    in_valid = 0;
    if (!exp_e && st) begin
      chk1({name, " w_en"}, mem_w_en, 1'b1);
      chk({name, " waddr"}, mem_waddr, a & ~32'h3);
      chk({name, " wmask"}, 32'(mem_wmask), 32'(exp_mask));
      chk({name, " wdata"}, mem_wdata, exp_wd);
    end else if (!exp_e) begin
      chk1({name, " r_en"}, mem_r_en, 1'b1);
      chk({name, " raddr"}, mem_raddr, a & ~32'h3);
    end
    k = 1;
    while (!out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, " latency"}, 32'(k), 32'(exp_lat));
    chk({name, " rdata"}, out_rdata, exp_r);
    chk1({name, " err"}, out_err, exp_e);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; in_is_store = 1; in_funct3 = 3'd2; in_addr = 32'h80000010; in_wdata = 32'h55555555;
      @(posedge clk); #1;
      chk({name, " held rdata"}, out_rdata, exp_r);
      chk1({name, " held valid"}, out_valid, 1'b1);
      chk1({name, " held in_ready"}, in_ready, 1'b0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk1({name, " released"}, out_valid, 1'b0);
    chk1({name, " idle"}, in_ready, 1'b1);
  endtask

  initial begin
    rst = 0;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    txn("LB",      0, 3'd0, 32'h80000003, 0, 32'hFFFFFF80, 0, 3, 0, 0, 0, 0);
    txn("LHU",     0, 3'd5, 32'h80000002, 0, 32'h000080FF, 0, 3, 0, 0, 0, 0);
    txn("LH",      0, 3'd1, 32'h80000002, 0, 32'hFFFF80FF, 0, 3, 0, 0, 0, 0);
    txn("LW hold", 0, 3'd2, 32'h80000004, 0, 32'h11223344, 0, 3, 0, 0, 5, 0);
    txn("LBU",     0, 3'd4, 32'h80000009, 0, 32'h000000F0, 0, 3, 0, 0, 0, 0);
    txn("LB pos",  0, 3'd0, 32'h80000008, 0, 32'h0000000D, 0, 3, 0, 0, 0, 0);
    txn("SB",      1, 3'd0, 32'h80000001, 32'hDEADBEAA, 0, 0, 2, 8'h02, 32'h0000AA00, 2, 0);
    txn("LW sb",   0, 3'd2, 32'h80000000, 0, 32'h80FFAA34, 0, 3, 0, 0, 0, 0);
    txn("SH",      1, 3'd1, 32'h80000006, 32'h12345678, 0, 0, 2, 8'h0C, 32'h56780000, 0, 0);
    txn("LW sh",   0, 3'd2, 32'h80000004, 0, 32'h56783344, 0, 3, 0, 0, 0, 0);
    txn("SW mis",  1, 3'd2, 32'h80000002, 32'hFFFFFFFF, 0, 1, 1, 0, 0, 0, 0);
    txn("LH mis",  0, 3'd1, 32'h80000001, 0, 0, 1, 1, 0, 0, 2, 0);
    txn("LD f3",   0, 3'd3, 32'h80000000, 0, 0, 1, 1, 0, 0, 0, 0);
    txn("SBU f3",  1, 3'd4, 32'h80000000, 32'h1, 0, 1, 1, 0, 0, 0, 0);
    txn("LW rdy",  0, 3'd2, 32'h80000008, 0, 32'hCAFEF00D, 0, 3, 0, 0, 0, 1);
    txn("SW rdy",  1, 3'd2, 32'h80000020, 32'hA5A5A5A5, 0, 0, 2, 8'h0F, 32'hA5A5A5A5, 0, 1);
    @(posedge clk); #1;
    in_valid = 1; in_is_store = 1; in_funct3 = 3'd2; in_addr = 32'h8000000C; in_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    in_valid = 0;
    chk1("rst-mid w_en before", mem_w_en, 1'b1);
    #2 rst = 1;
    #1;
    chk1("rst-mid w_en async drop", mem_w_en, 1'b0);
    chk1("rst-mid in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 0;
    chk1("rst-mid in_ready after", in_ready, 1'b1);
    chk1("rst-mid out_valid after", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    txn("LW after rst", 0, 3'd2, 32'h8000000C, 0, 32'h0BADC0DE, 0, 3, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
